// File: rtl/ycr_pm_pkg.sv
// Power-management state encodings shared by the sleep controller and the CSR/debug views of state_o.
package ycr_pm_pkg;

    localparam logic [2:0] YCR_PM_RUN    = 3'd0;
    localparam logic [2:0] YCR_PM_DRAIN  = 3'd1;
    localparam logic [2:0] YCR_PM_SLPREQ = 3'd2;
    localparam logic [2:0] YCR_PM_SLEEP  = 3'd3;
    localparam logic [2:0] YCR_PM_WAKE   = 3'd4;

    typedef enum logic [2:0] {
        RUN    = YCR_PM_RUN,
        DRAIN  = YCR_PM_DRAIN,
        SLPREQ = YCR_PM_SLPREQ,
        SLEEP  = YCR_PM_SLEEP,
        WAKE   = YCR_PM_WAKE
    } type_ycr_pm_state_e;

endpackage

// File: rtl/ycr_sat_cnt.sv
// Saturating up-counter: holds at all-ones until clr or rst; val is registered, sat is combinational.
module ycr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] val,
    output logic         sat
);

    assign sat = &val;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            val <= '0;
        end else if (inc && !sat) begin
            val <= val + 1'b1;
        end
    end

endmodule

// File: rtl/ycr_sleep_ctrl.sv
// Core sleep/wake sequencer on the always-on clock; all outputs registered.
// Wake in SLEEP -> wake_req_o next cycle; wfi_done_o WAKE_DLY cycles after clk_en_i is seen high.
module ycr_sleep_ctrl
    import ycr_pm_pkg::*;
#(
    parameter int NUM_WAKE_SRC = 4,
    parameter int IDLE_CNT_W   = 8,
    parameter int WAKE_DLY     = 2,
    parameter int SLP_CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sleep_en_i,
    input  logic                    wfi_req_i,
    input  logic                    pipe_idle_i,
    input  logic [NUM_WAKE_SRC-1:0] wake_src_i,
    input  logic [NUM_WAKE_SRC-1:0] wake_mask_i,
    input  logic                    dbg_halt_req_i,
    input  logic [IDLE_CNT_W-1:0]   idle_thresh_i,
    input  logic                    clk_en_i,
    output logic                    sleep_req_o,
    output logic                    wake_req_o,
    output logic                    wfi_done_o,
    output logic [2:0]              state_o,
    output logic [SLP_CNT_W-1:0]    sleep_cycles_o
);

    localparam int DLY_W = $clog2(WAKE_DLY + 1);

    logic [2:0]            state, state_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [DLY_W-1:0]      dly_cnt, dly_cnt_nxt;
    logic                  clk_seen, clk_seen_nxt;
    logic                  sleep_req_nxt, wake_req_nxt, wfi_done_nxt;
    logic                  wake;
    logic                  slp_sat;

    assign wake = (|(wake_src_i & wake_mask_i)) | dbg_halt_req_i;

    always_comb begin
        state_nxt     = state;
        idle_cnt_nxt  = idle_cnt;
        dly_cnt_nxt   = dly_cnt;
        clk_seen_nxt  = clk_seen;
        sleep_req_nxt = 1'b0;
        wake_req_nxt  = 1'b0;
        wfi_done_nxt  = 1'b0;
        case (state)
            YCR_PM_RUN: begin
                if (wfi_req_i) begin
                    if (wake) begin
                        wfi_done_nxt = 1'b1;
                    end else if (sleep_en_i) begin
                        state_nxt    = YCR_PM_DRAIN;
                        idle_cnt_nxt = '0;
                    end
                end
            end
            YCR_PM_DRAIN: begin
                if (wake) begin
                    state_nxt    = YCR_PM_RUN;
                    wfi_done_nxt = 1'b1;
                end else if (!wfi_req_i) begin
                    state_nxt = YCR_PM_RUN;
                end else if (pipe_idle_i) begin
                    // >= keeps the counter from running past a threshold lowered mid-drain
                    if (idle_cnt >= idle_thresh_i) begin
                        state_nxt     = YCR_PM_SLPREQ;
                        sleep_req_nxt = 1'b1;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt_nxt = '0;
                end
            end
            YCR_PM_SLPREQ: begin
                if (wake) begin
                    state_nxt    = YCR_PM_WAKE;
                    wake_req_nxt = 1'b1;
                    clk_seen_nxt = 1'b0;
                end else if (!clk_en_i) begin
                    state_nxt = YCR_PM_SLEEP;
                end else begin
                    sleep_req_nxt = 1'b1;
                end
            end
            YCR_PM_SLEEP: begin
                // an unexpected clock re-enable is handled like any other wake
                if (wake || clk_en_i) begin
                    state_nxt    = YCR_PM_WAKE;
                    wake_req_nxt = 1'b1;
                    clk_seen_nxt = 1'b0;
                end
            end
            YCR_PM_WAKE: begin
                if (!clk_seen) begin
                    if (clk_en_i) begin
                        clk_seen_nxt = 1'b1;
                        dly_cnt_nxt  = DLY_W'(WAKE_DLY - 1);
                    end else begin
                        wake_req_nxt = 1'b1;
                    end
                end else if (dly_cnt == '0) begin
                    state_nxt    = YCR_PM_RUN;
                    wfi_done_nxt = 1'b1;
                    clk_seen_nxt = 1'b0;
                end else begin
                    dly_cnt_nxt = dly_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = YCR_PM_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= YCR_PM_RUN;
            idle_cnt    <= '0;
            dly_cnt     <= '0;
            clk_seen    <= 1'b0;
            sleep_req_o <= 1'b0;
            wake_req_o  <= 1'b0;
            wfi_done_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_cnt_nxt;
            dly_cnt     <= dly_cnt_nxt;
            clk_seen    <= clk_seen_nxt;
            sleep_req_o <= sleep_req_nxt;
            wake_req_o  <= wake_req_nxt;
            wfi_done_o  <= wfi_done_nxt;
        end
    end

    assign state_o = state;

    ycr_sat_cnt #(
        .W (SLP_CNT_W)
    ) u_slp_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((state == YCR_PM_SLEEP) && !slp_sat),
        .clr (1'b0),
        .val (sleep_cycles_o),
        .sat (slp_sat)
    );

endmodule
